// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage
// (CPU) and the debug/loader port (DBG). The CPU wins by default. DBG gets
// CPU-idle cycles, a one-cycle steal after a run of blocked requests, or
// every cycle while hold mode is on.
module dmem_arbiter #(
  parameter logic [31:0] BASE         = 32'h0000_2000,
  parameter int          DEPTH        = 512,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_mem_read,
  input  logic        cpu_mem_write,
  input  logic [31:0] cpu_adr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_adr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_hold,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {NORMAL, STEAL, HOLD} state_t;

  // registered DBG response, launched on the grant edge
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dbg_resp_t;

  // 33-bit end bound so BASE near the top of the map cannot wrap
  localparam logic [32:0] ADR_END  = {1'b0, BASE} + 33'(4 * DEPTH);
  localparam logic [7:0]  CNT_LAST = 8'(STARVE_LIMIT - 1);

  state_t    state, state_nxt;
  logic [7:0] starve_cnt, starve_nxt;
  dbg_resp_t resp_q, resp_d;

  logic cpu_active;
  logic dbg_legal;
  logic dbg_own;
  logic stall_i;
  logic gnt_i;

  // request decode: CPU activity and DBG address legality
  always_comb begin
    cpu_active = cpu_mem_read | cpu_mem_write;
    dbg_legal  = (dbg_adr[1:0] == 2'b00) && (dbg_adr >= BASE) &&
                 ({1'b0, dbg_adr} < ADR_END);
  end

  // state and starvation counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // next state, ownership, stall and grant for this cycle
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    dbg_own    = 1'b0;
    stall_i    = 1'b0;
    gnt_i      = 1'b0;
    case (state)
      NORMAL: begin
        if (cpu_active) begin
          if (dbg_req) begin
            // blocked: count it, and steal once the run is long enough
            if (starve_cnt == CNT_LAST) begin
              state_nxt  = STEAL;
              starve_nxt = '0;
            end else begin
              starve_nxt = starve_cnt + 8'd1;
            end
          end else begin
            starve_nxt = '0;
          end
        end else begin
          starve_nxt = '0;
          if (dbg_req) begin
            dbg_own = 1'b1;
            gnt_i   = 1'b1;
          end
        end
      end
      STEAL: begin
        // a dropped request turns the steal into a plain CPU cycle
        starve_nxt = '0;
        state_nxt  = NORMAL;
        if (dbg_req) begin
          dbg_own = 1'b1;
          stall_i = 1'b1;
          gnt_i   = 1'b1;
        end
      end
      HOLD: begin
        starve_nxt = '0;
        state_nxt  = NORMAL;
        dbg_own    = 1'b1;
        stall_i    = 1'b1;
        gnt_i      = dbg_req;
      end
      default: begin
        state_nxt  = NORMAL;
        starve_nxt = '0;
      end
    endcase
    if (dbg_hold) state_nxt = HOLD;
  end

  // memory-side mux and CPU/DBG combinational outputs, all zero in reset
  always_comb begin
    cpu_stall = 1'b0;
    dbg_gnt   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_adr   = '0;
    mem_wdata = '0;
    cpu_rdata = '0;
    if (rst) begin
      cpu_stall = stall_i;
      dbg_gnt   = gnt_i;
      if (dbg_own) begin
        // illegal DBG addresses are granted but never reach memory
        mem_read  = dbg_req & ~dbg_we & dbg_legal;
        mem_write = dbg_req &  dbg_we & dbg_legal;
        mem_adr   = dbg_adr;
        mem_wdata = dbg_wdata;
      end else begin
        mem_read  = cpu_mem_read;
        mem_write = cpu_mem_write;
        mem_adr   = cpu_adr;
        mem_wdata = cpu_wdata;
        cpu_rdata = mem_rdata;
      end
    end
  end

  // response for the access granted this cycle
  always_comb begin
    resp_d.valid = dbg_gnt;
    resp_d.err   = dbg_gnt & ~dbg_legal;
    resp_d.rdata = (dbg_gnt && dbg_legal && !dbg_we) ? mem_rdata : 32'h0;
  end

  // response register; reset discards anything pending
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) resp_q <= '0;
    else      resp_q <= resp_d;
  end

  assign dbg_rvalid = resp_q.valid;
  assign dbg_err    = resp_q.err;
  assign dbg_rdata  = resp_q.rdata;

endmodule
